cmlk_pulse_gen: RTL

CMLK_PULSE_GEN -- requirements
Module: cmlk_pulse_gen

---
 rtl/cmlk_pulse_gen_pkg.sv | 14 +
 rtl/cmlk_pulse_gen_if.sv | 28 ++
 rtl/cmlk_phase_cnt.sv | 26 ++
 rtl/cmlk_pulse_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cmlk_pulse_gen_pkg.sv
// Shared timing definitions for the cmlk pulse/timing generators.
// Holds the FSM state encoding and the default counter width.
package cmlk_pulse_gen_pkg;

    localparam int CMLK_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_INACTIVE = 2'd3
    } pg_state_t;

endpackage

// File: rtl/cmlk_pulse_gen_if.sv
// Control and pulse-output bundle between a controller and cmlk_pulse_gen.
// The controller drives the master side; the generator uses the slave side.
interface cmlk_pulse_gen_if
    import cmlk_pulse_gen_pkg::*;
#(
    parameter int CNT_W = CMLK_CNT_W
);
    logic             trig;
    logic             stop;
    logic             polarity;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic             sig;
    logic             busy;
    logic             done;

    modport master (
        output trig, stop, polarity, delay, width, period, count,
        input  sig, busy, done
    );

    modport slave (
        input  trig, stop, polarity, delay, width, period, count,
        output sig, busy, done
    );
endinterface

// File: rtl/cmlk_phase_cnt.sv
// Phase down-counter: load has priority over decrement, holds at zero.
// zero is combinational from the count register (no extra latency).
module cmlk_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/cmlk_pulse_gen.sv
// Burst pulse generator: delay, then count pulses of width/period; sig, busy, done registered.
// Phase counter is loaded with (phase length - 1); a phase ends on the cycle its counter reads zero.
module cmlk_pulse_gen
    import cmlk_pulse_gen_pkg::*;
#(
    parameter int CNT_W = CMLK_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    cmlk_pulse_gen_if.slave   bus
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] eff_w(input logic [CNT_W-1:0] w);
        return (w == '0) ? ONE : w;
    endfunction

    // Inactive length minus one; at least one inactive cycle.
    function automatic logic [CNT_W-1:0] inact_m1(input logic [CNT_W-1:0] p,
                                                  input logic [CNT_W-1:0] w);
        logic [CNT_W-1:0] we;
        we = eff_w(w);
        return (p > we) ? (p - we - ONE) : '0;
    endfunction

    pg_state_t        state;
    logic [CNT_W-1:0] s_width, s_period, s_count;
    logic             s_pol;
    logic [CNT_W-1:0] pulse_num;
    logic             sig_q, busy_q, done_q;

    logic             ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0] ph_val;
    logic             start, abort, last_pulse;

    assign start      = (state == ST_IDLE) && bus.trig && !bus.stop;
    assign abort      = (state != ST_IDLE) && bus.stop;
    assign last_pulse = (s_count != '0) && (pulse_num == s_count);

    // The delay value is captured directly by the phase counter at start.
    always_comb begin
        ph_load = 1'b0;
        ph_dec  = 1'b0;
        ph_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    ph_load = 1'b1;
                    ph_val  = (bus.delay == '0) ? (eff_w(bus.width) - ONE) : (bus.delay - ONE);
                end
            end
            ST_DELAY, ST_INACTIVE: begin
                if (ph_zero) begin
                    ph_load = 1'b1;
                    ph_val  = eff_w(s_width) - ONE;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ph_zero) begin
                    ph_load = 1'b1;
                    ph_val  = inact_m1(s_period, s_width);
                end else begin
                    ph_dec = 1'b1;
                end
            end
        endcase
        if (abort) begin
            ph_load = 1'b1;
            ph_dec  = 1'b0;
            ph_val  = '0;
        end
    end

    cmlk_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_width   <= '0;
            s_period  <= '0;
            s_count   <= '0;
            s_pol     <= 1'b0;
            pulse_num <= '0;
            sig_q     <= ~bus.polarity;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                sig_q  <= ~s_pol;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        sig_q <= ~bus.polarity;
                        if (start) begin
                            s_width  <= bus.width;
                            s_period <= bus.period;
                            s_count  <= bus.count;
                            s_pol    <= bus.polarity;
                            busy_q   <= 1'b1;
                            if (bus.delay == '0) begin
                                state     <= ST_ACTIVE;
                                sig_q     <= bus.polarity;
                                pulse_num <= ONE;
                            end else begin
                                state <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (ph_zero) begin
                            state     <= ST_ACTIVE;
                            sig_q     <= s_pol;
                            pulse_num <= ONE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (ph_zero) begin
                            sig_q <= ~s_pol;
                            if (last_pulse) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_INACTIVE;
                            end
                        end
                    end
                    ST_INACTIVE: begin
                        if (ph_zero) begin
                            state     <= ST_ACTIVE;
                            sig_q     <= s_pol;
                            // Saturate so continuous mode never wraps back onto a count match.
                            pulse_num <= (pulse_num == '1) ? pulse_num : (pulse_num + ONE);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.sig  = sig_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
